rgb_to_grayscale_stream: RTL and testbench

RGB_TO_GRAYSCALE_STREAM -- requirements
Module: rgb_to_grayscale_stream

---
 rtl/rgb_gray_pkg.sv | 21 ++
 rtl/rgb_chan_expand.sv | 13 +
 rtl/rgb_to_grayscale_stream.sv | 191 +++++++++++++++++++
 tb/tb_rgb_to_grayscale_stream.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_gray_pkg.sv
// Shared constants for the RGB-to-grayscale stream: per-mode channel weights,
// the rounding constant and the conversion mode encoding.
package rgb_gray_pkg;

    typedef enum logic {
        MODE_LUMA = 1'b0,
        MODE_AVG  = 1'b1
    } mode_e;

    // BT.601 luma weights, scaled so the three sum to 256
    localparam logic [7:0] LUMA_WR = 8'd77;
    localparam logic [7:0] LUMA_WG = 8'd150;
    localparam logic [7:0] LUMA_WB = 8'd29;

    localparam logic [7:0] AVG_WR = 8'd85;
    localparam logic [7:0] AVG_WG = 8'd86;
    localparam logic [7:0] AVG_WB = 8'd85;

    localparam logic [16:0] ROUND_CONST = 17'd128;

endpackage

// File: rtl/rgb_chan_expand.sv
// Widens a W-bit colour channel to 8 bits by repeating its bit pattern, so
// full scale maps to 255 and zero stays zero.
module rgb_chan_expand #(
    parameter int W = 5
) (
    input  logic [W-1:0] chan_in,
    output logic [7:0]   chan_out
);

    // Four copies always reach at least 8 bits for W >= 2; keep the top byte
    assign chan_out = 8'({4{chan_in}} >> (4 * W - 8));

endmodule

// File: rtl/rgb_to_grayscale_stream.sv
// Three-stage valid/ready RGB-to-grayscale pipeline with frame sideband.
// Optional threshold mask output is enabled by defining RGB2GRAY_THRESH_EN.
module rgb_to_grayscale_stream
    import rgb_gray_pkg::*;
#(
    parameter int RED_W   = 5,
    parameter int GREEN_W = 6,
    parameter int BLUE_W  = 5,
    parameter int OUT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RED_W-1:0]   RED,
    input  logic [GREEN_W-1:0] GREEN,
    input  logic [BLUE_W-1:0]  BLUE,
    input  logic               mode,
    input  logic               sop_in,
    input  logic               eop_in,
    input  logic               valid_in,
    output logic               ready_in,
`ifdef RGB2GRAY_THRESH_EN
    input  logic [7:0]         thresh,
    output logic [0:0]         mask_out,
`endif
    output logic [OUT_W-1:0]   GRAYSCALE,
    output logic               sop_out,
    output logic               eop_out,
    output logic               valid_out,
    input  logic               ready_out,
    output logic [31:0]        pix_count
);

    logic [7:0] r8, g8, b8;

    rgb_chan_expand #(.W(RED_W))   u_exp_r (.chan_in(RED),   .chan_out(r8));
    rgb_chan_expand #(.W(GREEN_W)) u_exp_g (.chan_in(GREEN), .chan_out(g8));
    rgb_chan_expand #(.W(BLUE_W))  u_exp_b (.chan_in(BLUE),  .chan_out(b8));

    logic        s1_valid_q, s1_valid_d, s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
    logic [7:0]  s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
    mode_e       s1_mode_q, s1_mode_d;
    logic        s2_valid_q, s2_valid_d, s2_sop_q, s2_sop_d, s2_eop_q, s2_eop_d;
    logic [15:0] s2_pr_q, s2_pr_d, s2_pg_q, s2_pg_d, s2_pb_q, s2_pb_d;
    logic        s3_valid_q, s3_valid_d, s3_sop_q, s3_sop_d, s3_eop_q, s3_eop_d;
    logic [7:0]  s3_gray_q, s3_gray_d;
    logic [31:0] pix_count_q, pix_count_d;
    logic        s1_en, s2_en, s3_en, in_xfer, out_xfer;
    logic [7:0]  wr, wg, wb, gray8;
    logic [16:0] sum;
`ifdef RGB2GRAY_THRESH_EN
    logic        mask_q, mask_d;
`endif

    // A stage loads whenever it is empty or its current pixel moves on, so
    // bubbles collapse even while the output is stalled.
    always_comb begin
        s3_en    = !s3_valid_q || ready_out;
        s2_en    = !s2_valid_q || s3_en;
        s1_en    = !s1_valid_q || s2_en;
        ready_in = s1_en && !rst;
        in_xfer  = valid_in && ready_in;
        out_xfer = valid_out && ready_out;

        s1_valid_d = s1_valid_q;
        s1_r_d     = s1_r_q;
        s1_g_d     = s1_g_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s1_sop_d   = s1_sop_q;
        s1_eop_d   = s1_eop_q;
        if (s1_en) begin
            s1_valid_d = in_xfer;
            if (in_xfer) begin
                s1_r_d    = r8;
                s1_g_d    = g8;
                s1_b_d    = b8;
                s1_mode_d = mode_e'(mode);
                s1_sop_d  = sop_in;
                s1_eop_d  = eop_in;
            end
        end

        wr = (s1_mode_q == MODE_AVG) ? AVG_WR : LUMA_WR;
        wg = (s1_mode_q == MODE_AVG) ? AVG_WG : LUMA_WG;
        wb = (s1_mode_q == MODE_AVG) ? AVG_WB : LUMA_WB;

        s2_valid_d = s2_valid_q;
        s2_pr_d    = s2_pr_q;
        s2_pg_d    = s2_pg_q;
        s2_pb_d    = s2_pb_q;
        s2_sop_d   = s2_sop_q;
        s2_eop_d   = s2_eop_q;
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_pr_d  = 16'(wr) * 16'(s1_r_q);
                s2_pg_d  = 16'(wg) * 16'(s1_g_q);
                s2_pb_d  = 16'(wb) * 16'(s1_b_q);
                s2_sop_d = s1_sop_q;
                s2_eop_d = s1_eop_q;
            end
        end

        // Weights sum to at most 256, so the rounded result always fits a byte
        sum   = 17'(s2_pr_q) + 17'(s2_pg_q) + 17'(s2_pb_q) + ROUND_CONST;
        gray8 = 8'(sum >> 8);

        s3_valid_d = s3_valid_q;
        s3_gray_d  = s3_gray_q;
        s3_sop_d   = s3_sop_q;
        s3_eop_d   = s3_eop_q;
`ifdef RGB2GRAY_THRESH_EN
        mask_d     = mask_q;
`endif
        if (s3_en) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_gray_d = gray8;
                s3_sop_d  = s2_sop_q;
                s3_eop_d  = s2_eop_q;
`ifdef RGB2GRAY_THRESH_EN
                mask_d    = (gray8 >= thresh);
`endif
            end
        end

        pix_count_d = pix_count_q;
        if (out_xfer) begin
            pix_count_d = pix_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            s1_g_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= MODE_LUMA;
            s1_sop_q    <= 1'b0;
            s1_eop_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_pr_q     <= '0;
            s2_pg_q     <= '0;
            s2_pb_q     <= '0;
            s2_sop_q    <= 1'b0;
            s2_eop_q    <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_gray_q   <= '0;
            s3_sop_q    <= 1'b0;
            s3_eop_q    <= 1'b0;
            pix_count_q <= '0;
`ifdef RGB2GRAY_THRESH_EN
            mask_q      <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_r_q      <= s1_r_d;
            s1_g_q      <= s1_g_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            s1_sop_q    <= s1_sop_d;
            s1_eop_q    <= s1_eop_d;
            s2_valid_q  <= s2_valid_d;
            s2_pr_q     <= s2_pr_d;
            s2_pg_q     <= s2_pg_d;
            s2_pb_q     <= s2_pb_d;
            s2_sop_q    <= s2_sop_d;
            s2_eop_q    <= s2_eop_d;
            s3_valid_q  <= s3_valid_d;
            s3_gray_q   <= s3_gray_d;
            s3_sop_q    <= s3_sop_d;
            s3_eop_q    <= s3_eop_d;
            pix_count_q <= pix_count_d;
`ifdef RGB2GRAY_THRESH_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // Outputs are forced quiet during reset so nothing transfers on that cycle
    assign valid_out = s3_valid_q && !rst;
    assign sop_out   = s3_sop_q && !rst;
    assign eop_out   = s3_eop_q && !rst;
    assign GRAYSCALE = rst ? '0 : OUT_W'({s3_gray_q, s3_gray_q} >> (16 - OUT_W));
    assign pix_count = rst ? '0 : pix_count_q;
`ifdef RGB2GRAY_THRESH_EN
    assign mask_out  = rst ? 1'b0 : mask_q;
`endif

endmodule

// File: tb/tb_rgb_to_grayscale_stream.sv
// Scoreboard bench for rgb_to_grayscale_stream at default widths (5/6/5 -> 12).
// The threshold scenario is compiled only when RGB2GRAY_THRESH_EN is defined.
module tb_rgb_to_grayscale_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  RED;
    logic [5:0]  GREEN;
    logic [4:0]  BLUE;
    logic        mode, sop_in, eop_in, valid_in, ready_in;
    logic [11:0] GRAYSCALE;
    logic        sop_out, eop_out, valid_out, ready_out;
    logic [31:0] pix_count;
`ifdef RGB2GRAY_THRESH_EN
    logic [7:0]  thresh;
    logic [0:0]  mask_out;
`endif

    typedef struct packed {
        logic [11:0] gray;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    logic [4:0]  lat_r   [5] = '{5'd30, 5'd30, 5'd31, 5'd31, 5'd0};
    logic [5:0]  lat_g   [5] = '{6'd50, 6'd50, 6'd63, 6'd63, 6'd0};
    logic [4:0]  lat_b   [5] = '{5'd30, 5'd30, 5'd31, 5'd31, 5'd0};
    logic        lat_m   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] lat_exp [5] = '{12'hDDD, 12'hE8E, 12'hFFF, 12'hFFF, 12'h000};

    rgb_to_grayscale_stream dut (
        .clk       (clk),
        .rst       (rst),
        .RED       (RED),
        .GREEN     (GREEN),
        .BLUE      (BLUE),
        .mode      (mode),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
`ifdef RGB2GRAY_THRESH_EN
        .thresh    (thresh),
        .mask_out  (mask_out),
`endif
        .GRAYSCALE (GRAYSCALE),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    // Bit i (from the MSB) of the widened byte is channel bit (W-1 - i mod W)
    function automatic logic [7:0] widen(input logic [7:0] c, input int w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = c[w - 1 - (i % w)];
        return r;
    endfunction

    function automatic logic [11:0] model(input logic [4:0] r, input logic [5:0] g,
                                          input logic [4:0] b, input logic m);
        int wr, wg, wb, sum;
        logic [7:0] g8;
        if (m) begin wr = 85; wg = 86; wb = 85; end
        else   begin wr = 77; wg = 150; wb = 29; end
        sum = wr * int'(widen({3'b0, r}, 5)) + wg * int'(widen({2'b0, g}, 6))
            + wb * int'(widen({3'b0, b}, 5)) + 128;
        g8 = 8'(sum / 256);
        return {g8, g8[7:4]};
    endfunction

    task automatic send_and_wait(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b,
                                 input logic m, output logic acc, output int lat,
                                 output logic [11:0] gray, output logic sop, output logic eop,
                                 output logic mask);
        @(negedge clk);
        RED = r; GREEN = g; BLUE = b; mode = m;
        sop_in = 1'b1; eop_in = 1'b1; valid_in = 1'b1; ready_out = 1'b1;
        #1;
        acc = ready_in;
        lat = 0; gray = '0; sop = 1'b0; eop = 1'b0; mask = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
            #1;
            if (valid_out) begin
                lat = k; gray = GRAYSCALE; sop = sop_out; eop = eop_out;
`ifdef RGB2GRAY_THRESH_EN
                mask = mask_out;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; ready_out = 1'b1; sop_in = 1'b0; eop_in = 1'b0;
        RED = '0; GREEN = '0; BLUE = '0; mode = 1'b0;
`ifdef RGB2GRAY_THRESH_EN
        thresh = 8'd0;
`endif
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b0) $display("[TB] FAIL reset_valid_out: got %b want 0", valid_out); else passes++;
        checks++; if (GRAYSCALE !== 12'h000) $display("[TB] FAIL reset_gray: got %h want 000", GRAYSCALE); else passes++;
        checks++; if (sop_out !== 1'b0) $display("[TB] FAIL reset_sop: got %b want 0", sop_out); else passes++;
        checks++; if (eop_out !== 1'b0) $display("[TB] FAIL reset_eop: got %b want 0", eop_out); else passes++;
        checks++; if (pix_count !== 32'd0) $display("[TB] FAIL reset_pix_count: got %0d want 0", pix_count); else passes++;
        checks++; if (ready_in !== 1'b0) $display("[TB] FAIL reset_ready_in: got %b want 0", ready_in); else passes++;
`ifdef RGB2GRAY_THRESH_EN
        checks++; if (mask_out !== 1'b0) $display("[TB] FAIL reset_mask: got %b want 0", mask_out); else passes++;
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ready_in !== 1'b1) $display("[TB] FAIL ready_after_reset: got %b want 1", ready_in); else passes++;
    endtask

    task automatic test_latency();
        logic acc, sop, eop, mask;
        int lat;
        logic [11:0] gray;
        for (int i = 0; i < 5; i++) begin
            send_and_wait(lat_r[i], lat_g[i], lat_b[i], lat_m[i], acc, lat, gray, sop, eop, mask);
            checks++; if (acc !== 1'b1) $display("[TB] FAIL lat_accept[%0d]: got %b want 1", i, acc); else passes++;
            checks++; if (lat != 3) $display("[TB] FAIL latency[%0d]: got %0d want 3", i, lat); else passes++;
            checks++; if (gray !== lat_exp[i]) $display("[TB] FAIL gray[%0d]: got %h want %h", i, gray, lat_exp[i]); else passes++;
            checks++; if ({sop, eop} !== 2'b11) $display("[TB] FAIL sideband[%0d]: got %b want 11", i, {sop, eop}); else passes++;
        end
        @(negedge clk);
        #1;
        checks++; if (pix_count !== 32'd5) $display("[TB] FAIL lat_pix_count: got %0d want 5", pix_count); else passes++;
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        int got = 0;
        sb.delete();
        ready_out = 1'b1;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    @(negedge clk);
                    RED = 5'($urandom_range(0, 31)); GREEN = 6'($urandom_range(0, 63));
                    BLUE = 5'($urandom_range(0, 31)); mode = 1'(i % 2);
                    sop_in = (i == 0); eop_in = (i == N - 1); valid_in = 1'b1;
                    #1;
                    checks++;
                    if (ready_in !== 1'b1) $display("[TB] FAIL b2b_ready[%0d]: got %b want 1", i, ready_in);
                    else begin
                        passes++;
                        sb.push_back('{model(RED, GREEN, BLUE, mode), sop_in, eop_in});
                    end
                end
                @(negedge clk);
                valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
            end
            begin
                for (int c = 0; c < N + 20 && got < N; c++) begin
                    @(negedge clk);
                    #1;
                    if (valid_out && ready_out) begin
                        exp_t e;
                        checks++;
                        if (sb.size() == 0) $display("[TB] FAIL b2b_extra: got %h with empty scoreboard", GRAYSCALE);
                        else begin
                            e = sb.pop_front();
                            if ({GRAYSCALE, sop_out, eop_out} !== e)
                                $display("[TB] FAIL b2b_out[%0d]: got %h/%b%b want %h/%b%b", got, GRAYSCALE, sop_out, eop_out, e.gray, e.sop, e.eop);
                            else passes++;
                        end
                        got++;
                    end
                end
            end
        join
        checks++; if (got != N) $display("[TB] FAIL b2b_count: got %0d want %0d", got, N); else passes++;
    endtask

    task automatic test_burst_random();
        localparam int N = 100;
        int got = 0;
        sb.delete();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        fork
            begin
                int i = 0;
                logic [4:0] r; logic [5:0] g; logic [4:0] b; logic m;
                r = 5'($urandom_range(0, 31)); g = 6'($urandom_range(0, 63));
                b = 5'($urandom_range(0, 31)); m = 1'($urandom_range(0, 1));
                for (int t = 0; t < 3000 && i < N; t++) begin
                    @(negedge clk);
                    RED = r; GREEN = g; BLUE = b; mode = m;
                    sop_in = (i == 0); eop_in = (i == N - 1);
                    valid_in = ($urandom_range(0, 3) != 0);
                    #1;
                    if (valid_in && ready_in) begin
                        sb.push_back('{model(r, g, b, m), sop_in, eop_in});
                        i++;
                        r = 5'($urandom_range(0, 31)); g = 6'($urandom_range(0, 63));
                        b = 5'($urandom_range(0, 31)); m = 1'($urandom_range(0, 1));
                    end
                end
                @(negedge clk);
                valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
            end
            begin
                logic held = 1'b0;
                logic [13:0] held_val = '0;
                for (int c = 0; c < 4000 && got < N; c++) begin
                    @(negedge clk);
                    ready_out = 1'($urandom_range(0, 1));
                    #1;
                    if (held) begin
                        checks++;
                        if ({valid_out, GRAYSCALE, sop_out, eop_out} !== {1'b1, held_val})
                            $display("[TB] FAIL stall_hold: got %b/%h want 1/%h", valid_out, {GRAYSCALE, sop_out, eop_out}, held_val);
                        else passes++;
                    end
                    held = valid_out && !ready_out;
                    held_val = {GRAYSCALE, sop_out, eop_out};
                    if (valid_out && ready_out) begin
                        exp_t e;
                        checks++;
                        if (sb.size() == 0) $display("[TB] FAIL burst_extra: got %h with empty scoreboard", GRAYSCALE);
                        else begin
                            e = sb.pop_front();
                            if ({GRAYSCALE, sop_out, eop_out} !== e)
                                $display("[TB] FAIL burst_out[%0d]: got %h/%b%b want %h/%b%b", got, GRAYSCALE, sop_out, eop_out, e.gray, e.sop, e.eop);
                            else passes++;
                        end
                        got++;
                    end
                end
            end
        join
        ready_out = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (got != N) $display("[TB] FAIL burst_count: got %0d want %0d", got, N); else passes++;
        checks++; if (sb.size() != 0) $display("[TB] FAIL burst_leftover: got %0d want 0", sb.size()); else passes++;
        checks++; if (pix_count !== 32'd100) $display("[TB] FAIL burst_pix_count: got %0d want 100", pix_count); else passes++;
    endtask

    task automatic test_reset_midstream();
        int spurious = 0;
        logic acc, sop, eop, mask;
        int lat;
        logic [11:0] gray;
        @(negedge clk);
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            RED = 5'(i + 3); GREEN = 6'(i + 7); BLUE = 5'(i + 1); mode = 1'b0; valid_in = 1'b1;
            #1;
            checks++; if (ready_in !== 1'b1) $display("[TB] FAIL mid_fill[%0d]: got %b want 1", i, ready_in); else passes++;
        end
        @(negedge clk);
        valid_in = 1'b0; rst = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0) $display("[TB] FAIL mid_rst_valid: got %b want 0", valid_out); else passes++;
        @(negedge clk);
        rst = 1'b0; ready_out = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (valid_out) spurious++;
            @(negedge clk);
        end
        #1;
        checks++; if (spurious != 0) $display("[TB] FAIL mid_spurious: got %0d outputs want 0", spurious); else passes++;
        checks++; if (pix_count !== 32'd0) $display("[TB] FAIL mid_pix_count: got %0d want 0", pix_count); else passes++;
        send_and_wait(5'd30, 6'd50, 5'd30, 1'b0, acc, lat, gray, sop, eop, mask);
        checks++; if (lat != 3) $display("[TB] FAIL mid_latency: got %0d want 3", lat); else passes++;
        checks++; if (gray !== 12'hDDD) $display("[TB] FAIL mid_gray: got %h want DDD", gray); else passes++;
    endtask

`ifdef RGB2GRAY_THRESH_EN
    task automatic test_thresh();
        logic acc, sop, eop, mask;
        int lat;
        logic [11:0] gray;
        thresh = 8'd221;
        send_and_wait(5'd30, 6'd50, 5'd30, 1'b0, acc, lat, gray, sop, eop, mask);
        checks++; if (lat != 3 || mask !== 1'b1) $display("[TB] FAIL thresh_221: got lat %0d mask %b want 3/1", lat, mask); else passes++;
        thresh = 8'd222;
        send_and_wait(5'd30, 6'd50, 5'd30, 1'b0, acc, lat, gray, sop, eop, mask);
        checks++; if (lat != 3 || mask !== 1'b0) $display("[TB] FAIL thresh_222: got lat %0d mask %b want 3/0", lat, mask); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_burst_random();
        test_reset_midstream();
`ifdef RGB2GRAY_THRESH_EN
        test_thresh();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
